insn_encoder: RTL and testbench
===============================

Name: insn_encoder

Overview:
- Assembles RV32I instruction words from decoded fields: opcode, funct3, funct7, rs1, rs2, rd, a 32-bit immediate and a format selector.
- It is the inverse of the instruction-register field decoder.
- Feeds self-test and debug instruction-injection paths toward the fetch/IR interface.
- Input and output use valid/ready handshakes, decoupled by a small FIFO.

Parameters:
- DEPTH, 2, FIFO entries between the encode stage and the output; power of two, ≥2.

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept a bundle
- fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
- opcode  input  7  opcode field
- funct3  input  3  funct3 field
- funct7  input  7  funct7 field (R only)
- rs1  input  5  source register 1
- rs2  input  5  source register 2
- rd  input  5  destination register
- imm  input  32  signed byte-offset/value immediate
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head
- out_insn  output  32  encoded instruction word
- out_err  output  1  head entry flagged unencodable
- enc_count  output  16  encoded-word counter (feature-gated)
- err_count  output  16  error-word counter (feature-gated)

Behaviour:
- Reset (rst=0, async): count=0, FIFO pointers 0, all storage 0, out_valid=0, out_insn=0, out_err=0, counters 0. A reset mid-stream discards all queued entries.
- Handshake rules:
  - in_ready = (count < DEPTH); it is registered-state only, with no combinational path from out_ready.
  - Push on in_valid & in_ready.
  - Pop on out_valid & out_ready.
  - out_valid = (count != 0).
  - out_insn and out_err come from storage[rd_ptr].
- Latency: a bundle accepted in cycle N is visible at the output in cycle N+1 when the FIFO was empty. Encoding is combinational ahead of the write.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- When full, a push is refused even if a pop occurs in the same cycle.
- Pointers wrap modulo DEPTH. Order is strictly FIFO.
- Encoding (bit lists are MSB-first concatenations):
  - R: funct7, rs2, rs1, funct3, rd, opcode.
  - I: imm[11:0], rs1, funct3, rd, opcode. Error unless imm equals sign-extend of imm[11:0].
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode. Same range check as I.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode. Error unless imm[0]=0 and imm fits signed 13 bits.
  - U: imm[31:12], rd, opcode. Error unless imm[11:0]=0.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode. Error unless imm[0]=0 and imm fits signed 21 bits.
  - fmt 6 or 7: error.
- On error: the stored word is 32'h00000013 (addi x0,x0,0) and out_err=1 for that entry. The entry still occupies a slot and still pops normally.
- Unused fields for a format are ignored; no check is made on them.

Optional Feature:
- Macro INSN_ENCODER_STATS_EN.
- Defined:
  - enc_count increments on every push.
  - err_count increments on every push with an error.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: enc_count and err_count are tied to 0 and no counter flops are built.

Test Plan:
- R fmt, op=0x33, f3=0, f7=0, rs1=1, rs2=2, rd=3, out_ready=1 -> next cycle out_valid=1, out_insn=0x002081B3, out_err=0.
- I fmt, op=0x13, rd=1, rs1=0, imm=0xFFFFFFFF -> 0xFFF00093. Then imm=2048 -> out_insn=0x00000013, out_err=1.
- B fmt, op=0x63, rs1=1, rs2=2, f3=0, imm=-4 -> 0xFE208EE3. Then imm=-3 -> err=1, NOP word.
- U fmt, op=0x37, rd=5, imm=0x12345000 -> 0x123452B7. J fmt, op=0x6F, rd=1, imm=0x800 -> 0x001000EF.
- DEPTH=2, out_ready=0, push 3 distinct R words:
  - in_ready goes 0 after the 2nd accept, so the 3rd is held off.
  - Raise out_ready: words emerge in order 1,2,3.
  - A full + pop cycle does not accept.
- Two entries queued, then assert rst=0 for one cycle -> out_valid=0 and in_ready=1 immediately with no clock edge, out_insn=0. With INSN_ENCODER_STATS_EN, counters read 0; after 1 good and 1 bad push they read enc=2, err=1.

Source files
------------

// File: rtl/insn_encoder.sv
// rtl/insn_encoder.sv - RV32I instruction word assembler with valid/ready FIFO output (optional stats: INSN_ENCODER_STATS_EN)
module insn_encoder #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic        out_err,
  output logic [15:0] enc_count,
  output logic [15:0] err_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [31:0]   mem_insn [DEPTH];
  logic          mem_err  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [31:0] raw_word;
  logic        bad;
  logic [31:0] enc_word;
  logic        enc_err;
  logic        push;
  logic        pop;

  // Range checks: the immediate must survive truncation to the field width and re-extension.
  logic fits12;
  logic fits13;
  logic fits21;
  assign fits12 = (imm == {{20{imm[11]}}, imm[11:0]});
  assign fits13 = (imm == {{19{imm[12]}}, imm[12:0]});
  assign fits21 = (imm == {{11{imm[20]}}, imm[20:0]});

  // Combinational field packing and legality check per format.
  always_comb begin
    raw_word = NOP_WORD;
    bad      = 1'b1;
    case (fmt)
      FMT_R: begin
        raw_word = {funct7, rs2, rs1, funct3, rd, opcode};
        bad      = 1'b0;
      end
      FMT_I: begin
        raw_word = {imm[11:0], rs1, funct3, rd, opcode};
        bad      = !fits12;
      end
      FMT_S: begin
        raw_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        bad      = !fits12;
      end
      FMT_B: begin
        raw_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        bad      = imm[0] || !fits13;
      end
      FMT_U: begin
        raw_word = {imm[31:12], rd, opcode};
        bad      = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        raw_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        bad      = imm[0] || !fits21;
      end
      default: begin
        raw_word = NOP_WORD;
        bad      = 1'b1;
      end
    endcase
  end

  // Unencodable bundles are replaced by a harmless NOP so the consumer never sees garbage.
  assign enc_word = bad ? NOP_WORD : raw_word;
  assign enc_err  = bad;

  // Ready depends on occupancy only, so there is no path from out_ready to in_ready.
  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_insn  = mem_insn[rd_ptr];
  assign out_err   = mem_err[rd_ptr];

  // Storage write on push; a reset wipes every slot so stale words never reappear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_insn[i] <= '0;
        mem_err[i]  <= 1'b0;
      end
    end else if (push) begin
      mem_insn[wr_ptr] <= enc_word;
      mem_err[wr_ptr]  <= enc_err;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef INSN_ENCODER_STATS_EN
  logic [15:0] enc_cnt_q;
  logic [15:0] err_cnt_q;

  // Saturating counters of accepted words and of accepted words flagged unencodable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (push) begin
      if (enc_cnt_q != 16'hFFFF) enc_cnt_q <= enc_cnt_q + 16'd1;
      if (enc_err && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign enc_count = enc_cnt_q;
  assign err_count = err_cnt_q;
`else
  assign enc_count = 16'd0;
  assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_insn_encoder.sv
// tb/tb_insn_encoder.sv - table-driven bench for insn_encoder
module tb_insn_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [4:0]  rd = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_insn;
  logic        out_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  int checks = 0;
  int failures = 0;

  insn_encoder #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
    .out_err(out_err), .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] exp_insn;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    fmt = v.fmt; opcode = v.op; funct3 = v.f3; funct7 = v.f7;
    rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; imm = v.imm;
  endtask

  function automatic vec_t rword(input string n, input logic [4:0] r);
    vec_t v;
    v = '{n, 3'd0, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, r, 32'd0,
          32'h0020_8033 | (32'(r) << 7), 1'b0};
    return v;
  endfunction

  initial begin
    vec_t w1, w2, w3, good, badv;
    vecs.push_back('{"r_add",   3'd0, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0,        32'h002081B3, 1'b0});
    vecs.push_back('{"i_neg1",  3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 32'hFFF00093, 1'b0});
    vecs.push_back('{"i_2048",  3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd2048,     32'h00000013, 1'b1});
    vecs.push_back('{"i_m2048", 3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'hFFFFF800, 32'h80000093, 1'b0});
    vecs.push_back('{"s_sw",    3'd2, 7'h23, 3'd2, 7'h00, 5'd2, 5'd5, 5'd0, 32'hFFFFFFF8, 32'hFE512C23, 1'b0});
    vecs.push_back('{"b_m4",    3'd3, 7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0});
    vecs.push_back('{"b_m3",    3'd3, 7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFD, 32'h00000013, 1'b1});
    vecs.push_back('{"b_4096",  3'd3, 7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd4096,     32'h00000013, 1'b1});
    vecs.push_back('{"u_lui",   3'd4, 7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h12345000, 32'h123452B7, 1'b0});
    vecs.push_back('{"u_low",   3'd4, 7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h12345001, 32'h00000013, 1'b1});
    vecs.push_back('{"j_800",   3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h00000800, 32'h001000EF, 1'b0});
    vecs.push_back('{"j_big",   3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h00100000, 32'h00000013, 1'b1});
    vecs.push_back('{"fmt6",    3'd6, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0,        32'h00000013, 1'b1});

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_insn",  out_insn,       32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    chk("rst_enc_count", 32'(enc_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Table: one push per cycle, consumer always ready, head checked the cycle after accept
    out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
      chk({vecs[i].name, "_insn"},  out_insn,       vecs[i].exp_insn);
      chk({vecs[i].name, "_err"},   32'(out_err),   32'(vecs[i].exp_err));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Fill to full with consumer stalled
    w1 = rword("w1", 5'd7); w2 = rword("w2", 5'd8); w3 = rword("w3", 5'd9);
    out_ready = 1'b0;
    drive(w1); in_valid = 1'b1;
    @(posedge clk); #1;
    chk("full_ready1", 32'(in_ready), 32'd1);
    drive(w2);
    @(posedge clk); #1;
    chk("full_ready2", 32'(in_ready), 32'd0);
    drive(w3);
    @(posedge clk); #1;
    chk("full_held_ready", 32'(in_ready), 32'd0);
    chk("full_head_w1",    out_insn,      w1.exp_insn);
    // Full plus pop: pop happens, w3 is refused
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("fullpop_head_w2", out_insn,       w2.exp_insn);
    chk("fullpop_ready",   32'(in_ready),  32'd1);
    // w3 accepted now alongside pop of w2
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("order_head_w3", out_insn,       w3.exp_insn);
    chk("order_valid3",  32'(out_valid), 32'd1);
    @(posedge clk); #1;
    chk("order_empty",   32'(out_valid), 32'd0);

    // Mid-stream asynchronous reset with two entries queued
    out_ready = 1'b0;
    drive(w1); in_valid = 1'b1;
    @(posedge clk); #1;
    drive(w2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_ready", 32'(in_ready), 32'd0);
`ifdef INSN_ENCODER_STATS_EN
    chk("pre_rst_enc_nz", 32'(enc_count != 16'd0), 32'd1);
`endif
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    chk("arst_out_insn",  out_insn,       32'd0);
    chk("arst_enc_count", 32'(enc_count), 32'd0);
    chk("arst_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // One good and one bad push after reset
    good = vecs[0];
    badv = vecs[2];
    out_ready = 1'b1;
    drive(good); in_valid = 1'b1;
    @(posedge clk); #1;
    drive(badv);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_bad_err", 32'(out_err), 32'd1);
`ifdef INSN_ENCODER_STATS_EN
    chk("stats_enc", 32'(enc_count), 32'd2);
    chk("stats_err", 32'(err_count), 32'd1);
`else
    chk("stats_enc_tied", 32'(enc_count), 32'd0);
    chk("stats_err_tied", 32'(err_count), 32'd0);
`endif
    @(posedge clk); #1;
    chk("final_empty", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
